// File: rtl/fpmul_pkg.sv
// Shared types and constants for the sequential single-precision multiplier.
// Holds the controller state encoding, IEEE field widths and the result packer.
package fpmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int EXP_BIAS  = 127;
  localparam int EXP_MAX   = 255;
  localparam int FRAC_W    = 23;
  localparam int EXP_W     = 8;
  localparam int MUL_STEPS = 4;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [31:0] fp_pack(input logic sgn,
                                          input logic [EXP_W-1:0] exp,
                                          input logic [FRAC_W-1:0] frac);
    return {sgn, exp, frac};
  endfunction

endpackage

// File: rtl/fpmul_seq_ctrl_vedic12.sv
// 12x12 unsigned multiplier built from four 6x6 Urdhva-Tiryagbhyam cross products.
// Purely combinational; the controller registers its output once per step.
module vedic12 (
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic [23:0] z
);

  logic [11:0] ll, lh, hl, hh;
  logic [12:0] mid;

  assign ll  = x[5:0]  * y[5:0];
  assign lh  = x[5:0]  * y[11:6];
  assign hl  = x[11:6] * y[5:0];
  assign hh  = x[11:6] * y[11:6];
  assign mid = {1'b0, lh} + {1'b0, hl};

  // Cross terms sit in the middle 6-bit column; the sum cannot exceed 24 bits.
  assign z = {hh, ll} + {5'b0, mid, 6'b0};

endmodule

// File: rtl/fpmul_seq_ctrl.sv
// Sequential IEEE-754 single multiplier: one shared 12x12 multiplier over four
// steps, then exponent/normalise/special-case handling and a valid/ready output.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// MUL   | issue four partial products, accumulate each one edge later
// NORM  | accumulator complete; result formed and registered on exit
// DONE  | out_valid high, p held until out_ready
module fpmul_seq_ctrl
  import fpmul_pkg::*;
#(
  parameter int EXP_BIAS = fpmul_pkg::EXP_BIAS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);

  state_t      state;
  logic [31:0] a_q, b_q;
  logic [1:0]  cnt;
  logic [1:0]  pp_step;
  logic        pp_vld;
  logic [23:0] pp_q;
  logic [47:0] acc;

  logic [23:0] ma, mb;
  logic [11:0] mul_x, mul_y;
  logic [23:0] mul_z;
  logic [47:0] pp_ext;

  assign ma = {1'b1, a_q[FRAC_W-1:0]};
  assign mb = {1'b1, b_q[FRAC_W-1:0]};

  always_comb begin
    mul_x = ma[11:0];
    mul_y = mb[11:0];
    case (cnt)
      2'd1:    mul_y = mb[23:12];
      2'd2:    mul_x = ma[23:12];
      2'd3: begin
        mul_x = ma[23:12];
        mul_y = mb[23:12];
      end
      default: ;
    endcase
  end

  vedic12 u_mul (
    .x(mul_x),
    .y(mul_y),
    .z(mul_z)
  );

  always_comb begin
    pp_ext = {24'b0, pp_q};
    case (pp_step)
      2'd1, 2'd2: pp_ext = {12'b0, pp_q, 12'b0};
      2'd3:       pp_ext = {pp_q, 24'b0};
      default:    ;
    endcase
  end

  logic [EXP_W-1:0]  ea, eb;
  logic              sgn;
  logic signed [9:0] exp_n;
  logic [FRAC_W-1:0] frac;
  logic [31:0]       res;

  assign ea  = a_q[30:23];
  assign eb  = b_q[30:23];
  assign sgn = a_q[31] ^ b_q[31];

  always_comb begin
    exp_n = 10'(ea) + 10'(eb) - 10'(EXP_BIAS) + 10'(acc[47]);
    frac  = acc[47] ? acc[46:24] : acc[45:23];
    if ((ea == 8'(EXP_MAX) && eb == '0) || (eb == 8'(EXP_MAX) && ea == '0))
      res = QNAN;
    else if (ea == 8'(EXP_MAX) || eb == 8'(EXP_MAX))
      res = fp_pack(sgn, 8'(EXP_MAX), '0);
    else if (ea == '0 || eb == '0)
      res = fp_pack(sgn, '0, '0);
    else if (exp_n >= 10'sd255)
      res = fp_pack(sgn, 8'(EXP_MAX), '0);
    else if (exp_n <= 10'sd0)
      res = fp_pack(sgn, '0, '0);
    else
      res = fp_pack(sgn, exp_n[7:0], frac);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      busy      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pp_q      <= '0;
      pp_step   <= '0;
      pp_vld    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            cnt      <= '0;
            acc      <= '0;
            pp_vld   <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          if (pp_vld)
            acc <= acc + pp_ext;
          // The last product lands in the accumulator one edge after it is issued.
          if (pp_vld && pp_step == 2'(MUL_STEPS - 1)) begin
            pp_vld <= 1'b0;
            state  <= NORM;
          end else begin
            pp_q    <= mul_z;
            pp_step <= cnt;
            pp_vld  <= 1'b1;
            if (cnt != 2'(MUL_STEPS - 1))
              cnt <= cnt + 2'd1;
          end
        end
        NORM: begin
          p         <= res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_seq_ctrl.sv
// Scoreboard bench for fpmul_seq_ctrl: directed operand pairs with hand-computed
// products, latency tracking, backpressure hold and mid-operation reset.
module tb_fpmul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic        ov_prev = 1'b0;

  fpmul_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: latency on out_valid rise, product on each output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) begin
        if (lat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL latency: out_valid rose at cycle %0d with no pending accept", cyc);
        end else begin
          chk("latency", 32'(cyc), 32'(lat_q.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL product: unexpected result %h", p);
        end else begin
          chk("product", p, exp_q.pop_front());
        end
      end
      ov_prev <= out_valid;
    end else begin
      ov_prev <= 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    wait_ready();
    exp_q.push_back(e);
    lat_q.push_back(cyc + 1 + 6);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", p, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;

    send(32'h3FC00000, 32'h40000000, 32'h40400000);
    send(32'h40400000, 32'hBF000000, 32'hBFC00000);
    send(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    send(32'h7F000000, 32'h7F000000, 32'h7F800000);
    send(32'h00000000, 32'h7F800000, 32'h7FC00000);
    send(32'h40400000, 32'h00000000, 32'h00000000);
    send(32'h7F800000, 32'hC0000000, 32'hFF800000);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    send(32'h3FC00000, 32'h40000000, 32'h40400000);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_p_hold", p, 32'h40400000);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    drain();

    // Reset in MUL step 2; the aborted operation produces nothing.
    @(negedge clk);
    a = 32'h40400000; b = 32'h40400000; in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_p", p, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;

    send(32'h3F800000, 32'h3F800000, 32'h3F800000);
    drain();
    repeat (10) @(negedge clk);
    chk("no_spurious_output", 32'(lat_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
